// File: rtl/switch_power_sink_multi.sv
// Multi-channel switch output sink producing per-channel ACK/NACK or STALL/GO responses by test mode.
// Optional accepted-flit counters and the ACCEPT_CNT_out port are built when SINK_STATS_EN is defined.
module switch_power_sink_multi #(
  parameter int          NCH           = 4,
  parameter int          FLITWIDTH     = 32,
  parameter int          TESTINGMODE   = 4,
  parameter int          FLOWCTRL      = 0,
  parameter int          MAX_REJECT    = 0,
  parameter int          ROTATE_PERIOD = 8,
  parameter int          THRESH        = 64,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          CNTW          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*FLITWIDTH-1:0] FLIT_in,
  input  logic [NCH-1:0]           VALID_in,
  input  logic [NCH-1:0]           FWDAUX1_in,
  output logic [NCH-1:0]           BWDAUX1_out,
  output logic [NCH-1:0]           BWDAUX2_out,
  output logic [NCH-1:0]           BWDAUX3_out
`ifdef SINK_STATS_EN
  ,
  output logic [NCH*CNTW-1:0]      ACCEPT_CNT_out
`endif
);

  localparam int MODE_IDLE    = 0;
  localparam int MODE_THROUGH = 1;
  localparam int MODE_CONG    = 2;
  localparam int MODE_NOARB   = 3;
  localparam int MODE_ROTATE  = 4;
  localparam int MODE_RANDOM  = 5;

  localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1;
  localparam int RW = (MAX_REJECT > 0) ? $clog2(MAX_REJECT + 1) : 1;

  localparam logic [TW-1:0] TOK_LAST = TW'(NCH - 1);
  localparam logic [PW-1:0] ROT_LAST = PW'(ROTATE_PERIOD - 1);
  localparam logic [RW-1:0] REJ_MAX  = RW'(MAX_REJECT);
  localparam logic [8:0]    THR9     = 9'(THRESH);
  localparam logic          BOUNDED  = (MAX_REJECT > 0);
  localparam logic [15:0]   TAPS     = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] seed_of(input int c);
    logic [15:0] s;
    s = SEED + 16'(c);
    seed_of = (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  logic [NCH-1:0] aux1_q, aux1_d;
  logic [NCH-1:0] aux2_q, aux2_d;
  logic [NCH-1:0] first_nack_q, first_nack_d;
  logic [RW-1:0]  rej_cnt_q [NCH];
  logic [RW-1:0]  rej_cnt_d [NCH];
  logic [15:0]    lfsr_q [NCH];
  logic [15:0]    lfsr_d [NCH];
  logic [TW-1:0]  tok_q, tok_d;
  logic [PW-1:0]  rot_cnt_q, rot_cnt_d;
  logic [NCH-1:0] nat_s, forced_s, acc_s, take_s;
  logic           flit_unused_s;

  assign flit_unused_s = ^FLIT_in;
  assign BWDAUX1_out   = aux1_q;
  assign BWDAUX2_out   = aux2_q;
  assign BWDAUX3_out   = '0;

  // Token rotation plus the per-channel accept/reject decision and response encoding.
  always_comb begin
    if (rot_cnt_q == ROT_LAST) begin
      rot_cnt_d = '0;
      tok_d     = (tok_q == TOK_LAST) ? '0 : tok_q + TW'(1);
    end else begin
      rot_cnt_d = rot_cnt_q + PW'(1);
      tok_d     = tok_q;
    end
    aux1_d       = '0;
    aux2_d       = '0;
    first_nack_d = first_nack_q;
    nat_s        = '0;
    forced_s     = '0;
    acc_s        = '0;
    take_s       = '0;
    for (int c = 0; c < NCH; c++) begin
      lfsr_d[c]    = lfsr_step(lfsr_q[c]);
      rej_cnt_d[c] = rej_cnt_q[c];
      forced_s[c]  = BOUNDED && (rej_cnt_q[c] == REJ_MAX);
      case (TESTINGMODE)
        MODE_THROUGH, MODE_NOARB: nat_s[c] = 1'b1;
        MODE_ROTATE:              nat_s[c] = (tok_q == TW'(c));
        MODE_RANDOM:              nat_s[c] = ({1'b0, lfsr_q[c][7:0]} >= THR9);
        default:                  nat_s[c] = 1'b0;
      endcase
      acc_s[c] = nat_s[c] | forced_s[c];
      if (FLOWCTRL != 0) begin
        // A flit is taken whenever it is offered while the previous response was GO.
        take_s[c] = VALID_in[c] & ~aux1_q[c];
        if (TESTINGMODE == MODE_IDLE) begin
          aux1_d[c] = 1'b0;
        end else if (acc_s[c]) begin
          aux1_d[c]    = 1'b0;
          rej_cnt_d[c] = '0;
        end else begin
          aux1_d[c]    = 1'b1;
          rej_cnt_d[c] = BOUNDED ? rej_cnt_q[c] + RW'(1) : '0;
        end
      end else if ((TESTINGMODE == MODE_IDLE) || !VALID_in[c]) begin
        aux1_d[c] = 1'b0;
        aux2_d[c] = 1'b0;
      end else if (acc_s[c]) begin
        aux1_d[c]    = 1'b1;
        aux2_d[c]    = 1'b1;
        rej_cnt_d[c] = '0;
        take_s[c]    = 1'b1;
      end else if ((TESTINGMODE != MODE_CONG) || !first_nack_q[c] || FWDAUX1_in[c]) begin
        aux2_d[c]       = 1'b1;
        first_nack_d[c] = 1'b1;
        rej_cnt_d[c]    = BOUNDED ? rej_cnt_q[c] + RW'(1) : '0;
      end else begin
        aux2_d[c] = 1'b0;
      end
    end
  end

  // Response, token, LFSR and rejection-bound state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aux1_q       <= '0;
      aux2_q       <= '0;
      first_nack_q <= '0;
      tok_q        <= '0;
      rot_cnt_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        rej_cnt_q[c] <= '0;
        lfsr_q[c]    <= seed_of(c);
      end
    end else begin
      aux1_q       <= aux1_d;
      aux2_q       <= aux2_d;
      first_nack_q <= first_nack_d;
      tok_q        <= tok_d;
      rot_cnt_q    <= rot_cnt_d;
      for (int c = 0; c < NCH; c++) begin
        rej_cnt_q[c] <= rej_cnt_d[c];
        lfsr_q[c]    <= lfsr_d[c];
      end
    end
  end

`ifdef SINK_STATS_EN
  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_d [NCH];

  // Saturating accepted-flit counters.
  always_comb begin
    ACCEPT_CNT_out = '0;
    for (int c = 0; c < NCH; c++) begin
      if (take_s[c] && (cnt_q[c] != {CNTW{1'b1}})) begin
        cnt_d[c] = cnt_q[c] + CNTW'(1);
      end else begin
        cnt_d[c] = cnt_q[c];
      end
      ACCEPT_CNT_out[c*CNTW +: CNTW] = cnt_q[c];
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
    end
  end
`else
  localparam int STATS_UNUSED_W = CNTW;
  logic stats_unused_s;
  assign stats_unused_s = ^take_s;
`endif

endmodule
